// File: rtl/proc_pkg.sv
// Types shared by the fetch unit and its op buffer.
package proc_pkg;
  localparam int WORD_W  = 32;
  localparam int IMM_BIT = 31;

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    DRAIN     = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] op;
    logic [WORD_W-1:0] imm32;
    logic [WORD_W-1:0] pc;
  } op_entry_t;

  function automatic logic has_imm(input logic [WORD_W-1:0] word);
    return word[IMM_BIT];
  endfunction
endpackage

// File: rtl/op_fifo.sv
// Synchronous FIFO of fetched op entries; the head entry is read straight from storage.
module op_fifo
  import proc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  op_entry_t                wdata,
  output op_entry_t                rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  op_entry_t      r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves the same cycle.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: rtl/op_fetch.sv
// Instruction fetch: word reads from imem, optional trailing imm32, buffered {op, imm32, pc}
// entries to the core, with redirect flush and drain of an abandoned in-flight read.
module op_fetch
  import proc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_adr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic [31:0] op,
  output logic [31:0] imm32,
  output logic [31:0] op_pc,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] fetch_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t   r_state;
  fetch_state_t   w_state_nxt;
  logic           r_mem_req;
  logic [31:0]    r_mem_adr;
  logic [31:0]    r_fetch_pc;
  logic [31:0]    r_op_lat;
  logic [31:0]    r_pc_lat;
  logic [31:0]    w_fetch_pc_nxt;
  logic [31:0]    w_redir_adr;
  logic           w_ack;
  logic           w_stalled;
  logic           w_push;
  logic           w_fifo_push;
  logic           w_pop;
  logic           w_latch;
  logic           w_req_nxt;
  logic [31:0]    w_adr_nxt;
  logic           w_full;
  logic           w_empty;
  logic [CW-1:0]  w_count;
  logic [CW-1:0]  w_count_nxt;
  op_entry_t      w_push_data;
  op_entry_t      w_head;

  assign w_ack       = r_mem_req && mem_ack;
  assign w_stalled   = r_mem_req && !mem_ack;
  assign w_redir_adr = redir_pc & ~32'h3;
  assign w_pop       = !w_empty && op_ready;
  assign w_fifo_push = w_push && (!w_full || w_pop);

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_push         = 1'b0;
    w_latch        = 1'b0;
    w_push_data    = '{op: mem_rdata, imm32: '0, pc: r_mem_adr};
    if (redir_valid) begin
      w_fetch_pc_nxt = w_redir_adr;
      w_state_nxt    = w_stalled ? DRAIN : FETCH_OP;
    end else begin
      unique case (r_state)
        FETCH_OP: if (w_ack) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          if (has_imm(mem_rdata)) begin
            w_latch     = 1'b1;
            w_state_nxt = FETCH_IMM;
          end else begin
            w_push = 1'b1;
          end
        end
        FETCH_IMM: if (w_ack) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          w_push         = 1'b1;
          w_push_data    = '{op: r_op_lat, imm32: mem_rdata, pc: r_pc_lat};
          w_state_nxt    = FETCH_OP;
        end
        DRAIN: if (w_ack) w_state_nxt = FETCH_OP;
        default: w_state_nxt = FETCH_OP;
      endcase
    end
  end

  always_comb begin
    w_count_nxt = w_count;
    if (redir_valid)                  w_count_nxt = '0;
    else if (w_fifo_push && !w_pop)   w_count_nxt = w_count + 1'b1;
    else if (!w_fifo_push && w_pop)   w_count_nxt = w_count - 1'b1;
  end

  // An unacked request is held as-is, whether it is live or being drained.
  always_comb begin
    w_req_nxt = r_mem_req;
    w_adr_nxt = r_mem_adr;
    if (!w_stalled) begin
      w_adr_nxt = w_fetch_pc_nxt;
      unique case (w_state_nxt)
        FETCH_IMM: w_req_nxt = 1'b1;
        FETCH_OP:  w_req_nxt = (w_count_nxt < CW'(DEPTH));
        default:   w_req_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= FETCH_OP;
      r_mem_req  <= 1'b0;
      r_mem_adr  <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_op_lat   <= '0;
      r_pc_lat   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_req_nxt;
      r_mem_adr  <= w_adr_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      if (w_latch) begin
        r_op_lat <= mem_rdata;
        r_pc_lat <= r_mem_adr;
      end
    end
  end

  op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_fifo_push),
    .pop   (w_pop),
    .flush (redir_valid),
    .wdata (w_push_data),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign mem_req  = r_mem_req;
  assign mem_adr  = r_mem_adr;
  assign fetch_pc = r_fetch_pc;
  assign op_valid = !w_empty;
  assign op       = w_head.op;
  assign imm32    = w_head.imm32;
  assign op_pc    = w_head.pc;
endmodule

// File: doc/op_fetch.md
# op_fetch

Instruction fetch unit that feeds `proc32`'s `op` input. It issues word reads to instruction memory starting at a reset PC and collects a 32-bit immediate when an op carries one. Completed {op, imm32, pc} entries are buffered in a small FIFO and presented to the core with a valid/ready handshake. It sits between the instruction memory port and the core's decode stage, and supports core-driven PC redirects (branch/jump/interrupt) with a full flush.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 4, output FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `mem_req`  out  1  read request to instruction memory
- `mem_adr`  out  32  word address (byte address, bits [1:0] = 0)
- `mem_ack`  in  1  read complete; `mem_rdata` valid this cycle
- `mem_rdata`  in  32  read data
- `redir_valid`  in  1  restart fetch at `redir_pc`, flush all buffered ops
- `redir_pc`  in  32  new fetch address (bits [1:0] ignored, forced 0)
- `op`  out  32  head-of-FIFO opcode word
- `imm32`  out  32  immediate for `op`; 0 if op has none
- `op_pc`  out  32  address of `op` word
- `op_valid`  out  1  head entry valid
- `op_ready`  in  1  core accepts head entry
- `fetch_pc`  out  32  address of next word to be requested

## Operation
- Op word bit 31 (`IMM_BIT`) = 1: the next sequential word is its imm32. Entry is pushed only after both words arrive.
- Memory protocol: `mem_req` is raised with `mem_adr` and held stable until a cycle with `mem_ack`=1. One outstanding request max. Data is taken on the ack cycle.
- FSM states:
  - FETCH_OP: request at `fetch_pc` only when FIFO count < DEPTH.
    - Ack with bit31=0: push {rdata, 0, adr}, stay.
    - Ack with bit31=1: latch op/pc, go FETCH_IMM.
  - FETCH_IMM: request at `fetch_pc` unconditionally (slot reserved). On ack, push {op, rdata, pc}, go FETCH_OP.
  - DRAIN: a redirect arrived while a request was unacked. Hold old req/adr until ack, discard data, go FETCH_OP.
- `fetch_pc` += 4 on every accepted ack (not in DRAIN). Wraps modulo 2^32, so 32'hFFFF_FFFC → 0.
- Redirect (highest priority):
  - FIFO cleared and `fetch_pc` ← `redir_pc` & ~3.
  - Any partial op is dropped.
  - Next state: DRAIN if req outstanding without ack this cycle, else FETCH_OP.
- Redirect coincident with `mem_ack`: data discarded, no DRAIN.
- Redirect coincident with `op_valid && op_ready`: pop is honored (core consumed it), then flush.
- Push and pop in same cycle: count unchanged; legal when full.
- Redirect during DRAIN: update `fetch_pc` again, remain in DRAIN.

## Timing
- Reset values: `mem_req`=0, `mem_adr`=RESET_PC, `fetch_pc`=RESET_PC, `op_valid`=0, `op`/`imm32`/`op_pc`=0. FSM=FETCH_OP, count=0.
- First `mem_req` is asserted on the first clock edge after `rst_n` deasserts.
- Reset mid-request drops `mem_req` immediately. Memory must tolerate an abandoned request.
- Back-to-back: after an ack in cycle N, the next request is presented in cycle N+1. Zero-wait memory gives 1 word/cycle.
- Op latency: ack of final word in cycle N → `op_valid` in cycle N+1 (FIFO empty case). FIFO outputs are registered from the head.
- `op_valid` drops the cycle after the redirect edge. The first post-redirect `mem_req` is at the cycle after the redirect (or after the drain ack).

## Structure
- Shared package `proc_pkg`:
  - `WORD_W`=32 and `IMM_BIT`=31
  - `fetch_state_t` enum {FETCH_OP, FETCH_IMM, DRAIN}
  - `op_entry_t` struct {op, imm32, pc}
- Sub-module `op_fifo`: synchronous FIFO of `op_entry_t`, DEPTH entries.
  - Ports: push, pop, flush, full, empty, count.
  - Flush has priority over push and pop the same cycle.
- FSM, address register and request logic stay in `op_fetch`.

## Test plan
- Reset, zero-wait memory returning 32'h0000_0011, 32'h0000_0022 → reqs at 0, 4; ops presented 0x11@pc0, 0x22@pc4 with imm32=0; first `op_valid` 2 cycles after reset release.
- Op 32'h8000_0005 at 0x10, word 32'hDEAD_BEEF at 0x14 → single entry {0x8000_0005, 0xDEADBEEF, 0x10}; next req at 0x18.
- `op_ready`=0, DEPTH=4 non-imm ops → exactly 4 acks then `mem_req` stays 0; one pop → one more req issued next cycle.
- Req at 0x20 stalled 3 cycles, `redir_valid` with `redir_pc`=0x103 in the stall → `mem_adr` stays 0x20 until ack, data discarded, next req at 0x100, no stale op emitted.
- Redirect between op (bit31=1) ack and imm ack → partial op dropped, FIFO empty, fetch resumes at `redir_pc`.
- `fetch_pc`=32'hFFFF_FFFC, non-imm op → next req at 32'h0000_0000; also `rst_n` low mid-request → all outputs return to reset values immediately.
